// File: rtl/bidir_deserializer.sv
// Serial-to-parallel receiver with per-frame MSB/LSB-first order, a single-entry
// valid/ready output register and sticky framing-error / overrun flags.
module bidir_deserializer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             sof,
   input  logic             dir,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_err
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_sh, w_sh_nxt, w_base;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
   logic               r_dir, w_dir_nxt, w_dir_use;
   logic [WIDTH-1:0]   r_out_data, w_out_data_nxt;
   logic               r_out_valid, w_out_valid_nxt;
   logic               r_frame_err, w_frame_err_nxt;
   logic               r_overrun, w_overrun_nxt;
   logic               w_accept, w_done, w_frame_evt, w_load, w_ovr_evt;

   // Next-state, shift datapath and output-register control
   always_comb begin
      w_state_nxt     = r_state;
      w_sh_nxt        = r_sh;
      w_cnt_nxt       = r_cnt;
      w_dir_nxt       = r_dir;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_frame_err_nxt = r_frame_err;
      w_overrun_nxt   = r_overrun;
      w_done          = 1'b0;
      w_frame_evt     = 1'b0;
      w_load          = 1'b0;
      w_ovr_evt       = 1'b0;
      w_dir_use       = sof ? dir : r_dir;
      w_base          = sof ? '0 : r_sh;
      w_cnt_inc       = sof ? CNT_W'(1) : r_cnt + CNT_W'(1);
      w_accept        = ser_valid && (sof || (r_state == SHIFT));

      if (w_accept) begin
         w_dir_nxt   = w_dir_use;
         w_frame_evt = sof && (r_state == SHIFT) && (r_cnt != '0);
         if (w_dir_use)
            w_sh_nxt = {ser_in, w_base[WIDTH-1:1]};
         else
            w_sh_nxt = {w_base[WIDTH-2:0], ser_in};
         if (w_cnt_inc == CNT_W'(WIDTH)) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = SHIFT;
         end
      end

      w_load    = w_done && (!r_out_valid || out_ready);
      w_ovr_evt = w_done && r_out_valid && !out_ready;

      if (w_load) begin
         w_out_data_nxt  = w_sh_nxt;
         w_out_valid_nxt = 1'b1;
      end else if (r_out_valid && out_ready) begin
         w_out_valid_nxt = 1'b0;
      end

      // A new error event takes priority over a simultaneous clear
      if (w_frame_evt)
         w_frame_err_nxt = 1'b1;
      else if (clr_err)
         w_frame_err_nxt = 1'b0;
      if (w_ovr_evt)
         w_overrun_nxt = 1'b1;
      else if (clr_err)
         w_overrun_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sh        <= '0;
         r_cnt       <= '0;
         r_dir       <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sh        <= w_sh_nxt;
         r_cnt       <= w_cnt_nxt;
         r_dir       <= w_dir_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = (r_state == SHIFT);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_bidir_deserializer.sv
// Directed bench for bidir_deserializer: expected words queued as frames are sent,
// popped and compared whenever the DUT hands a word over.
module tb_bidir_deserializer;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ser_in;
   logic             ser_valid;
   logic             sof;
   logic             dir;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             clr_err;

   int unsigned      checks   = 0;
   int unsigned      failures = 0;
   logic [WIDTH-1:0] exp_q[$];

   bidir_deserializer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .sof       (sof),
      .dir       (dir),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic beat(input logic s, input logic d, input logic b);
      ser_valid = 1'b1;
      sof       = s;
      dir       = d;
      ser_in    = b;
      @(posedge clk);
      #1;
      ser_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic d, input logic [WIDTH-1:0] w);
      for (int i = 0; i < int'(WIDTH); i++)
         beat(i == 0, d, d ? w[i] : w[int'(WIDTH) - 1 - i]);
   endtask

   // Scoreboard: every handshake must match the oldest queued word
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL unexpected_word observed=%0h expected=none", out_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            assert (out_data === e) else begin
               failures++;
               $error("FAIL word observed=%0h expected=%0h", out_data, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; sof = 1'b0; dir = 1'b0;
      out_ready = 1'b1; clr_err = 1'b0;
      idle(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_flags",     32'({frame_err, overrun}), 32'd0);
      rst = 1'b0;
      idle(1);

      // MSB first
      exp_q.push_back(4'b1011);
      beat(1'b1, 1'b0, 1'b1);
      chk("msb_busy_mid", 32'(busy), 32'd1);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      chk("msb_valid", 32'(out_valid), 32'd1);
      chk("msb_data",  32'(out_data),  32'hB);
      chk("msb_busy",  32'(busy),      32'd0);
      idle(1);
      chk("msb_valid_drop", 32'(out_valid), 32'd0);

      // LSB first, then a frame with dir toggled mid-frame
      exp_q.push_back(4'b1101);
      send(1'b1, 4'b1101);
      chk("lsb_data", 32'(out_data), 32'hD);
      exp_q.push_back(4'b1110);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      chk("lsb_dirlatch_data", 32'(out_data), 32'hE);
      idle(1);

      // Backpressure and overrun
      out_ready = 1'b0;
      exp_q.push_back(4'b1010);
      send(1'b0, 4'b1010);
      send(1'b0, 4'b0110);
      chk("ovr_data",    32'(out_data),  32'hA);
      chk("ovr_valid",   32'(out_valid), 32'd1);
      chk("ovr_flag",    32'(overrun),   32'd1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      chk("ovr_drained", 32'(out_valid), 32'd0);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      chk("ovr_clear",   32'(overrun),   32'd0);

      // Drain and load on the same edge
      exp_q.push_back(4'b0011);
      send(1'b0, 4'b0011);
      exp_q.push_back(4'b1100);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b0);
      chk("dl_a_held", 32'(out_data), 32'h3);
      out_ready = 1'b1;
      beat(1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      chk("dl_valid",   32'(out_valid), 32'd1);
      chk("dl_data",    32'(out_data),  32'hC);
      chk("dl_overrun", 32'(overrun),   32'd0);
      out_ready = 1'b1;
      idle(1);
      chk("dl_drained", 32'(out_valid), 32'd0);

      // Framing error: sof after two bits restarts the frame
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      exp_q.push_back(4'b0001);
      beat(1'b1, 1'b0, 1'b0);
      chk("fe_flag",   32'(frame_err), 32'd1);
      chk("fe_novalid", 32'(out_valid), 32'd0);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b1);
      chk("fe_data",   32'(out_data),  32'h1);
      chk("fe_valid",  32'(out_valid), 32'd1);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      chk("fe_clear",  32'(frame_err), 32'd0);

      // Stall mid-frame, then asynchronous reset
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b0, 1'b0, 1'b0);
      sof = 1'b1;
      idle(3);
      sof = 1'b0;
      chk("stall_busy",  32'(busy),      32'd1);
      chk("stall_flags", 32'(frame_err), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_data",  32'(out_data),  32'd0);
      chk("arst_busy",  32'(busy),      32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(4'b0101);
      send(1'b0, 4'b0101);
      chk("post_rst_data", 32'(out_data), 32'h5);
      idle(2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
